rx_control_unit: RTL and testbench

Receive control unit for the APB UART receiver peripheral. Sequences each serial frame:
- validates the start bit at its midpoint;
- gates the bit/packet timer;
- checks the stop bit;
- loads the receive buffer;
- maintains the data-ready, overrun and framing-error status bits read by the APB slave.

It sits between the start-bit edge detector, the timer (which produces shift_enable/packet_done), the shift register/stop-bit capture, and the APB register file.

---
 rtl/uart_rx_pkg.sv | 17 +
 rtl/rx_control_unit_flex_counter.sv | 55 +++++
 rtl/rx_control_unit.sv | 151 +++++++++++++++
 tb/tb_rx_control_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// The control unit and its half-period counter import these.
package uart_rx_pkg;

  localparam int BP_W           = 14;
  localparam int MIN_BIT_PERIOD = 2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_WAIT = 3'd1,
    START_CHK  = 3'd2,
    RECEIVE    = 3'd3,
    STOP_CHK   = 3'd4,
    LOAD       = 3'd5
  } rcu_state_t;

endpackage

// File: rtl/rx_control_unit_flex_counter.sv
// Loadable up-counter with a registered rollover flag.
// While clear is held the count is preloaded to 1, so the flag lines up with the
// final enabled cycle of a run of exactly rollover_val cycles.
module flex_counter #(
  parameter int NUM_CNT_BITS = 14
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  logic [NUM_CNT_BITS-1:0] count_r;
  logic [NUM_CNT_BITS-1:0] count_nxt_s;
  logic                    flag_r;
  logic                    flag_nxt_s;

  // Next count and next flag: clear preloads, enable advances and wraps back to 1.
  always_comb begin
    count_nxt_s = count_r;
    flag_nxt_s  = flag_r;
    if (clear) begin
      count_nxt_s = CNT_ONE;
      flag_nxt_s  = (rollover_val == CNT_ONE);
    end else if (count_enable) begin
      if (count_r == rollover_val) begin
        count_nxt_s = CNT_ONE;
      end else begin
        count_nxt_s = count_r + CNT_ONE;
      end
      flag_nxt_s = (count_nxt_s == rollover_val);
    end else begin
      count_nxt_s = count_r;
      flag_nxt_s  = flag_r;
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_r <= {NUM_CNT_BITS{1'b0}};
      flag_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      flag_r  <= flag_nxt_s;
    end
  end

  assign rollover_flag = flag_r;

endmodule

// File: rtl/rx_control_unit.sv
// Receive control unit: sequences one UART frame from start-bit validation to
// buffer load, and keeps the data-ready / overrun / framing-error status bits.
module rx_control_unit
  import uart_rx_pkg::*;
#(
  parameter int BP_W = uart_rx_pkg::BP_W
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [BP_W-1:0] bit_period,
  input  logic            start_bit_detected,
  input  logic            serial_in,
  input  logic            packet_done,
  input  logic            stop_bit,
  input  logic            data_read,
  output logic            enable_timer,
  output logic            sbc_clear,
  output logic            load_buffer,
  output logic            data_ready,
  output logic            overrun_error,
  output logic            framing_error
);

  rcu_state_t      state_r;
  rcu_state_t      state_nxt_s;
  logic [BP_W-1:0] half_period_s;
  logic            half_done_s;
  logic            bp_ok_s;
  logic            in_start_wait_s;

  logic enable_timer_r;
  logic sbc_clear_r;
  logic load_buffer_r;
  logic data_ready_r;
  logic overrun_error_r;
  logic framing_error_r;

  assign half_period_s   = bit_period >> 1;
  assign bp_ok_s         = (bit_period >= BP_W'(MIN_BIT_PERIOD));
  assign in_start_wait_s = (state_r == START_WAIT);

  flex_counter #(
    .NUM_CNT_BITS(BP_W)
  ) u_half_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (!in_start_wait_s),
    .count_enable (in_start_wait_s),
    .rollover_val (half_period_s),
    .rollover_flag(half_done_s)
  );

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_bit_detected && bp_ok_s) begin
          state_nxt_s = START_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START_WAIT: begin
        if (half_done_s) begin
          state_nxt_s = START_CHK;
        end else begin
          state_nxt_s = START_WAIT;
        end
      end
      START_CHK: begin
        if (!serial_in) begin
          state_nxt_s = RECEIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RECEIVE: begin
        if (packet_done) begin
          state_nxt_s = STOP_CHK;
        end else begin
          state_nxt_s = RECEIVE;
        end
      end
      STOP_CHK: begin
        if (stop_bit) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register; control outputs are registered from the next state so they
  // are high exactly while the state register holds the matching state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r        <= IDLE;
      enable_timer_r <= 1'b0;
      sbc_clear_r    <= 1'b0;
      load_buffer_r  <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      enable_timer_r <= (state_nxt_s == RECEIVE);
      sbc_clear_r    <= (state_nxt_s == START_WAIT) && (state_r != START_WAIT);
      load_buffer_r  <= (state_nxt_s == LOAD);
    end
  end

  // Status flags: a load or a framing-error set takes priority over a read.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_ready_r    <= 1'b0;
      overrun_error_r <= 1'b0;
      framing_error_r <= 1'b0;
    end else if (state_r == LOAD) begin
      data_ready_r <= 1'b1;
      if (data_read) begin
        overrun_error_r <= 1'b0;
        framing_error_r <= 1'b0;
      end else begin
        overrun_error_r <= overrun_error_r | data_ready_r;
      end
    end else if ((state_r == STOP_CHK) && !stop_bit) begin
      framing_error_r <= 1'b1;
      if (data_read) begin
        data_ready_r    <= 1'b0;
        overrun_error_r <= 1'b0;
      end
    end else if (data_read) begin
      data_ready_r    <= 1'b0;
      overrun_error_r <= 1'b0;
      framing_error_r <= 1'b0;
    end
  end

  assign enable_timer  = enable_timer_r;
  assign sbc_clear     = sbc_clear_r;
  assign load_buffer   = load_buffer_r;
  assign data_ready    = data_ready_r;
  assign overrun_error = overrun_error_r;
  assign framing_error = framing_error_r;

endmodule

// File: tb/tb_rx_control_unit.sv
// Self-checking bench for rx_control_unit: directed scenarios followed by
// randomized frames, checked against a frame-level model of the status bits.
`timescale 1ns/1ps
module tb_rx_control_unit;

  logic        clk;
  logic        n_rst;
  logic [13:0] bit_period;
  logic        start_bit_detected;
  logic        serial_in;
  logic        packet_done;
  logic        stop_bit;
  logic        data_read;
  logic        enable_timer;
  logic        sbc_clear;
  logic        load_buffer;
  logic        data_ready;
  logic        overrun_error;
  logic        framing_error;

  int checks;
  int failures;
  bit m_dr;
  bit m_ov;
  bit m_fe;

  rx_control_unit #(.BP_W(14)) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .bit_period        (bit_period),
    .start_bit_detected(start_bit_detected),
    .serial_in         (serial_in),
    .packet_done       (packet_done),
    .stop_bit          (stop_bit),
    .data_read         (data_read),
    .enable_timer      (enable_timer),
    .sbc_clear         (sbc_clear),
    .load_buffer       (load_buffer),
    .data_ready        (data_ready),
    .overrun_error     (overrun_error),
    .framing_error     (framing_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag);
    check_val({tag, ".data_ready"}, int'(data_ready), int'(m_dr));
    check_val({tag, ".overrun"}, int'(overrun_error), int'(m_ov));
    check_val({tag, ".framing"}, int'(framing_error), int'(m_fe));
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    m_dr = 1'b0;
    m_ov = 1'b0;
    m_fe = 1'b0;
    check_flags("read");
  endtask

  // One frame: lvl is the line at the start midpoint, stp the stop bit,
  // rd a read pulse (in LOAD for good frames, in STOP_CHK for bad ones).
  task automatic do_frame(input int bp, input bit lvl, input bit stp, input bit rd, input bit noise);
    int  h;
    int  k;
    int  n;
    bit  found;
    h = bp >> 1;
    bit_period = bp[13:0];
    serial_in = lvl;
    start_bit_detected = 1'b1;
    tick();
    start_bit_detected = 1'b0;
    check_val("sbc_clear_first", int'(sbc_clear), 1);
    found = 1'b0;
    k = 0;
    while (!found && k < h + 4) begin
      if (noise && !lvl) begin
        packet_done = 1'($urandom_range(0, 1));
        start_bit_detected = 1'($urandom_range(0, 1));
      end
      tick();
      k++;
      if (enable_timer) found = 1'b1;
    end
    packet_done = 1'b0;
    start_bit_detected = 1'b0;
    if (lvl) begin
      check_val("false_start_en", int'(found), 0);
      check_flags("false_start");
      serial_in = 1'b1;
      return;
    end
    check_val("start_latency", k, h + 1);
    serial_in = 1'($urandom_range(0, 1));
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) begin
      if (noise) start_bit_detected = 1'($urandom_range(0, 1));
      tick();
      check_val("recv_enable", int'(enable_timer), 1);
    end
    start_bit_detected = 1'b0;
    packet_done = 1'b1;
    tick();
    packet_done = 1'b0;
    stop_bit = stp;
    data_read = (!stp) && rd;
    check_val("stop_chk_enable", int'(enable_timer), 0);
    check_val("stop_chk_load", int'(load_buffer), 0);
    tick();
    stop_bit = 1'($urandom_range(0, 1));
    data_read = stp && rd;
    check_val("load_pulse", int'(load_buffer), int'(stp));
    if (!stp) begin
      m_fe = 1'b1;
      if (rd) begin
        m_dr = 1'b0;
        m_ov = 1'b0;
      end
    end else if (rd) begin
      m_dr = 1'b1;
      m_ov = 1'b0;
      m_fe = 1'b0;
    end else begin
      m_ov = m_ov | m_dr;
      m_dr = 1'b1;
    end
    tick();
    data_read = 1'b0;
    stop_bit = 1'b0;
    serial_in = 1'b1;
    check_val("load_single", int'(load_buffer), 0);
    check_flags("frame_end");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_dr = 1'b0;
    m_ov = 1'b0;
    m_fe = 1'b0;
    n_rst = 1'b0;
    bit_period = 14'd10;
    start_bit_detected = 1'b0;
    serial_in = 1'b1;
    packet_done = 1'b0;
    stop_bit = 1'b0;
    data_read = 1'b0;
    repeat (3) tick();
    check_val("rst_enable", int'(enable_timer), 0);
    check_val("rst_sbc", int'(sbc_clear), 0);
    check_val("rst_load", int'(load_buffer), 0);
    check_flags("rst");
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    // Good frame, then a second unread one for overrun.
    do_frame(10, 1'b0, 1'b1, 1'b0, 1'b0);
    do_frame(10, 1'b0, 1'b1, 1'b0, 1'b0);
    read_pulse();
    // Overrun avoided by a read coinciding with the second load.
    do_frame(7, 1'b0, 1'b1, 1'b0, 1'b0);
    do_frame(7, 1'b0, 1'b1, 1'b1, 1'b0);
    // False start, then framing error cleared by a read.
    do_frame(12, 1'b1, 1'b1, 1'b0, 1'b0);
    do_frame(2, 1'b0, 1'b0, 1'b0, 1'b0);
    read_pulse();
    // Framing-error set wins over a simultaneous read.
    do_frame(9, 1'b0, 1'b0, 1'b1, 1'b0);
    read_pulse();

    // Unconfigured bit period and stray packet_done in IDLE.
    for (int bp = 0; bp < 2; bp++) begin
      bit_period = 14'(bp);
      start_bit_detected = 1'b1;
      tick();
      start_bit_detected = 1'b0;
      for (int i = 0; i < 4; i++) begin
        check_val("guard_sbc", int'(sbc_clear), 0);
        check_val("guard_enable", int'(enable_timer), 0);
        tick();
      end
    end
    packet_done = 1'b1;
    tick();
    packet_done = 1'b0;
    repeat (3) begin
      tick();
      check_val("idle_pd_load", int'(load_buffer), 0);
    end
    check_flags("idle_pd");

    // Reset during RECEIVE after leaving a word pending.
    do_frame(6, 1'b0, 1'b1, 1'b0, 1'b0);
    bit_period = 14'd8;
    serial_in = 1'b0;
    start_bit_detected = 1'b1;
    tick();
    start_bit_detected = 1'b0;
    repeat (6) tick();
    check_val("pre_rst_enable", int'(enable_timer), 1);
    tick();
    tick();
    n_rst = 1'b0;
    #1;
    m_dr = 1'b0;
    m_ov = 1'b0;
    m_fe = 1'b0;
    check_val("midrst_enable", int'(enable_timer), 0);
    check_val("midrst_sbc", int'(sbc_clear), 0);
    check_val("midrst_load", int'(load_buffer), 0);
    check_flags("midrst");
    serial_in = 1'b1;
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    do_frame(10, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized frames with noise and random idle gaps.
    for (int f = 0; f < 40; f++) begin
      int  rbp;
      bit  rlvl;
      bit  rstp;
      bit  rrd;
      int  gap;
      rbp  = $urandom_range(2, 40);
      rlvl = ($urandom_range(0, 4) == 0);
      rstp = ($urandom_range(0, 3) != 0);
      rrd  = 1'($urandom_range(0, 1));
      do_frame(rbp, rlvl, rstp, rrd, 1'b1);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        data_read = ($urandom_range(0, 3) == 0);
        packet_done = 1'($urandom_range(0, 1));
        tick();
        if (data_read) begin
          m_dr = 1'b0;
          m_ov = 1'b0;
          m_fe = 1'b0;
        end
      end
      data_read = 1'b0;
      packet_done = 1'b0;
      tick();
      check_flags("gap");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
